// File: rtl/wb_pkg.sv
// Shared types and load-encoding constants for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wbsel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WB
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/half/word at the byte offset,
// extends it, and flags misaligned or reserved load encodings.
module load_align
  import wb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DWIDTH-1:0] rdata,
  output logic [DWIDTH-1:0] data,
  output logic              err
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{off, 3'b000} +: 8];
  assign half_v = rdata[{off[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DWIDTH-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(DWIDTH-8){1'b0}}, byte_v};
      F3_LH: begin
        data = {{(DWIDTH-16){half_v[15]}}, half_v};
        err  = off[0];
      end
      F3_LHU: begin
        data = {{(DWIDTH-16){1'b0}}, half_v};
        err  = off[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (off != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires one instruction per accept into the register file.
// Optional WB_BYPASS_EN adds combinational forwarding copies of the write port.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic [1:0]        wbsel_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic              retire_o,
`ifdef WB_BYPASS_EN
  output logic              byp_valid_o,
  output logic [4:0]        byp_rd_o,
  output logic [DWIDTH-1:0] byp_data_o,
`endif
  output logic              err_o
);

  wb_state_e         state, state_nxt;
  wbsel_e            sel;
  logic              accept, wb_load, wb_now;
  logic [4:0]        cap_rd;
  logic              cap_wren;
  logic [2:0]        cap_f3;
  logic [1:0]        cap_off;
  logic [DWIDTH-1:0] ld_data;
  logic              ld_err;
  logic [4:0]        wb_rd;
  logic [DWIDTH-1:0] wb_data;
  logic              wb_wren, wb_err;

  assign sel     = wbsel_e'(wbsel_i);
  assign ready_o = (state != S_WAIT_MEM);
  assign accept  = valid_i && ready_o;
  assign wb_load = (state == S_WAIT_MEM) && mem_rvalid_i;
  assign wb_now  = wb_load || (accept && sel != WB_MEM);

  load_align #(.DWIDTH(DWIDTH)) u_align (
    .funct3 (cap_f3),
    .off    (cap_off),
    .rdata  (mem_rdata_i),
    .data   (ld_data),
    .err    (ld_err)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_MEM: if (mem_rvalid_i) state_nxt = S_WB;
      default: begin
        if (accept) state_nxt = (sel == WB_MEM) ? S_WAIT_MEM : S_WB;
        else        state_nxt = S_IDLE;
      end
    endcase
  end

  // Non-loads write straight from the inputs; a completing load uses the captured fields.
  always_comb begin
    wb_rd   = rd_i;
    wb_wren = regwren_i;
    wb_err  = 1'b0;
    case (sel)
      WB_PC4:  wb_data = DWIDTH'(pc_i + AWIDTH'(4));
      WB_IMM:  wb_data = imm_i;
      default: wb_data = alu_res_i;
    endcase
    if (wb_load) begin
      wb_rd   = cap_rd;
      wb_wren = cap_wren;
      wb_err  = ld_err;
      wb_data = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_rd   <= '0;
      cap_wren <= 1'b0;
      cap_f3   <= '0;
      cap_off  <= '0;
    end else if (accept && sel == WB_MEM) begin
      cap_rd   <= rd_i;
      cap_wren <= regwren_i;
      cap_f3   <= funct3_i;
      cap_off  <= alu_res_i[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_o      <= '0;
      datawb_o  <= '0;
      regwren_o <= 1'b0;
      retire_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      regwren_o <= 1'b0;
      retire_o  <= 1'b0;
      err_o     <= 1'b0;
      if (wb_now) begin
        rd_o      <= wb_rd;
        datawb_o  <= wb_data;
        regwren_o <= wb_wren && (wb_rd != 5'd0) && !wb_err;
        retire_o  <= 1'b1;
        err_o     <= wb_err;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid_o = regwren_o;
  assign byp_rd_o    = rd_o;
  assign byp_data_o  = datawb_o;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: ALU/PC+4/IMM retires,
// load alignment and stalls, error loads, back-to-back flow and reset in WAIT_MEM.
module tb_writeback_stage;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [4:0]        rd_i = '0;
  logic              regwren_i = 1'b0;
  logic [1:0]        wbsel_i = '0;
  logic [2:0]        funct3_i = '0;
  logic [DWIDTH-1:0] alu_res_i = '0;
  logic [AWIDTH-1:0] pc_i = '0;
  logic [DWIDTH-1:0] imm_i = '0;
  logic              mem_rvalid_i = 1'b0;
  logic [DWIDTH-1:0] mem_rdata_i = '0;
  logic [4:0]        rd_o;
  logic [DWIDTH-1:0] datawb_o;
  logic              regwren_o;
  logic              retire_o;
  logic              err_o;
`ifdef WB_BYPASS_EN
  logic              byp_valid_o;
  logic [4:0]        byp_rd_o;
  logic [DWIDTH-1:0] byp_data_o;
`endif

  int checks = 0;
  int errors = 0;

  writeback_stage #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .rd_i         (rd_i),
    .regwren_i    (regwren_i),
    .wbsel_i      (wbsel_i),
    .funct3_i     (funct3_i),
    .alu_res_i    (alu_res_i),
    .pc_i         (pc_i),
    .imm_i        (imm_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rd_o         (rd_o),
    .datawb_o     (datawb_o),
    .regwren_o    (regwren_o),
    .retire_o     (retire_o),
`ifdef WB_BYPASS_EN
    .byp_valid_o  (byp_valid_o),
    .byp_rd_o     (byp_rd_o),
    .byp_data_o   (byp_data_o),
`endif
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] data,
                          input logic wren, input logic err, input bit chk_data);
    check({tag, "_rd"}, 32'(rd_o), 32'(rd));
    if (chk_data) check({tag, "_data"}, datawb_o, data);
    check({tag, "_wren"}, 32'(regwren_o), 32'(wren));
    check({tag, "_retire"}, 32'(retire_o), 32'd1);
    check({tag, "_err"}, 32'(err_o), 32'(err));
`ifdef WB_BYPASS_EN
    check({tag, "_byp_valid"}, 32'(byp_valid_o), 32'(wren));
    check({tag, "_byp_rd"}, 32'(byp_rd_o), 32'(rd));
    if (chk_data) check({tag, "_byp_data"}, byp_data_o, data);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] rd, input logic wren, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [31:0] alu,
                      input logic [31:0] pc, input logic [31:0] imm);
    valid_i   = 1'b1;
    rd_i      = rd;
    regwren_i = wren;
    wbsel_i   = sel;
    funct3_i  = f3;
    alu_res_i = alu;
    pc_i      = pc;
    imm_i     = imm;
  endtask

  // Load issued now; accept at next edge, rvalid in the following cycle.
  task automatic load_one(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rdata);
    send(rd, 1'b1, 2'd1, f3, alu, 32'h0, 32'h0);
    tick();
    valid_i = 1'b0;
    check("load_stall", 32'(ready_o), 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_rd", 32'(rd_o), 32'd0);
    check("rst_data", datawb_o, 32'd0);
    check("rst_wren", 32'(regwren_o), 32'd0);
    check("rst_retire", 32'(retire_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    tick();

    // rvalid while idle must not retire anything
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid_i = 1'b0;
    check("idle_rvalid_retire", 32'(retire_o), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);

    // ALU op
    send(5'd5, 1'b1, 2'd0, 3'b010, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    valid_i = 1'b0;
    check_wb("alu", 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
    tick();
    check("alu_after_retire", 32'(retire_o), 32'd0);
    check("alu_after_wren", 32'(regwren_o), 32'd0);
    check("alu_hold_rd", 32'(rd_o), 32'd5);
    check("alu_hold_data", datawb_o, 32'h0000_1234);

    // LB off=3, rvalid three cycles after accept
    send(5'd7, 1'b1, 2'd1, 3'b000, 32'h0000_0103, 32'h0, 32'h0);
    tick();
    valid_i = 1'b0;
    check("lb_stall1", 32'(ready_o), 32'd0);
    check("lb_stall1_retire", 32'(retire_o), 32'd0);
    tick();
    check("lb_stall2", 32'(ready_o), 32'd0);
    tick();
    check("lb_stall3", 32'(ready_o), 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h80FF_0011;
    tick();
    mem_rvalid_i = 1'b0;
    check_wb("lb", 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
    check("lb_wb_ready", 32'(ready_o), 32'd1);

    // Loads accepted during WB of the previous one (no bubble)
    load_one(5'd8, 3'b100, 32'h0000_0003, 32'h80FF_0011);
    check_wb("lbu", 5'd8, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    load_one(5'd9, 3'b001, 32'h0000_0001, 32'h1234_5678);
    check_wb("lh_misalign", 5'd9, 32'h0, 1'b0, 1'b1, 1'b0);
    load_one(5'd10, 3'b101, 32'h0000_0002, 32'hBEEF_0000);
    check_wb("lhu", 5'd10, 32'h0000_BEEF, 1'b1, 1'b0, 1'b1);
    load_one(5'd11, 3'b001, 32'h0000_0002, 32'h8001_0000);
    check_wb("lh_sext", 5'd11, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1);
    load_one(5'd12, 3'b000, 32'h0000_0001, 32'h1234_7F56);
    check_wb("lb_pos", 5'd12, 32'h0000_007F, 1'b1, 1'b0, 1'b1);
    load_one(5'd13, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    check_wb("lw", 5'd13, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    load_one(5'd14, 3'b010, 32'h0000_0002, 32'hDEAD_BEEF);
    check_wb("lw_misalign", 5'd14, 32'h0, 1'b0, 1'b1, 1'b0);
    load_one(5'd15, 3'b011, 32'h0000_0000, 32'hDEAD_BEEF);
    check_wb("reserved_f3", 5'd15, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check("err_clear", 32'(err_o), 32'd0);
    check("err_retire_clear", 32'(retire_o), 32'd0);

    // PC+4 and IMM to rd=0
    send(5'd1, 1'b1, 2'd2, 3'b000, 32'h0000_DEAD, 32'h0100_0FFC, 32'h0);
    tick();
    check_wb("pc4", 5'd1, 32'h0100_1000, 1'b1, 1'b0, 1'b1);
    send(5'd0, 1'b1, 2'd3, 3'b000, 32'h0, 32'h0, 32'h0000_ABCD);
    tick();
    check_wb("rd0", 5'd0, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1);

    // Four back-to-back ALU ops; the third does not write
    for (int i = 0; i < 4; i++) begin
      send(5'(20 + i), (i != 2), 2'd0, 3'b000, 32'h1000 + 32'(i), 32'h0, 32'h0);
      tick();
      check_wb($sformatf("b2b%0d", i), 5'(20 + i), 32'h1000 + 32'(i), (i != 2), 1'b0, 1'b1);
    end
    valid_i = 1'b0;
    tick();
    check("b2b_end_retire", 32'(retire_o), 32'd0);

    // Reset while a load is pending, then a stray rvalid
    send(5'd9, 1'b1, 2'd1, 3'b010, 32'h0, 32'h0, 32'h0);
    tick();
    valid_i = 1'b0;
    check("rstw_stall", 32'(ready_o), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rstw_rd", 32'(rd_o), 32'd0);
    check("rstw_data", datawb_o, 32'd0);
    rst = 1'b1;
    tick();
    check("rstw_ready", 32'(ready_o), 32'd1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0055;
    tick();
    mem_rvalid_i = 1'b0;
    check("rstw_stray_retire", 32'(retire_o), 32'd0);
    check("rstw_stray_wren", 32'(regwren_o), 32'd0);
    check("rstw_stray_data", datawb_o, 32'd0);
    check("rstw_stray_ready", 32'(ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

- Final pipeline stage: retires one instruction at a time from the memory stage into `register_file`.
- Selects the writeback source (ALU, load data, PC+4, immediate) and aligns and sign-extends load data.
- Waits on the data-memory read response when the instruction is a load.
- Drives the register file's `rd_i`, `datawb_i` and `regwren_i` from registered outputs.

## Interface
- `DWIDTH`, 32, data width.
- `AWIDTH`, 32, PC width.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  memory stage presents a retiring instruction.
- `ready_o`  out  1  stage can accept this cycle.
- `rd_i`  in  5  destination register.
- `regwren_i`  in  1  instruction writes `rd`.
- `wbsel_i`  in  2  source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM.
- `funct3_i`  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- `alu_res_i`  in  DWIDTH  ALU result; bits [1:0] are the load byte offset.
- `pc_i`  in  AWIDTH  instruction PC.
- `imm_i`  in  DWIDTH  immediate.
- `mem_rvalid_i`  in  1  load data valid.
- `mem_rdata_i`  in  DWIDTH  raw aligned word from data memory.
- `rd_o`  out  5  to `register_file` `rd_i`.
- `datawb_o`  out  DWIDTH  to `register_file` `datawb_i`.
- `regwren_o`  out  1  to `register_file` `regwren_i`.
- `retire_o`  out  1  one-cycle pulse per retired instruction.
- `err_o`  out  1  one-cycle pulse on a misaligned or illegal load.

## Operation
- States: IDLE, WAIT_MEM, WB.
- `ready_o` = 1 in IDLE and WB; 0 in WAIT_MEM.
- An instruction is accepted when `valid_i && ready_o`. On accept, `rd`, `regwren`, `wbsel`, `funct3`, `alu_res`, `pc` and `imm` are captured.
- Accept with `wbsel` != MEM: go to WB. Data is ALU = `alu_res`, PC+4 = `pc` + 4 truncated to DWIDTH, IMM = `imm`.
- Accept with `wbsel` = MEM: go to WAIT_MEM.
- WAIT_MEM + `mem_rvalid_i`: aligned data is captured, then go to WB.
- `mem_rvalid_i` is ignored outside WAIT_MEM.
- Load alignment uses byte offset `off` = `alu_res[1:0]`:
  - LB/LBU select byte `off`, sign- or zero-extended.
  - LH/LHU select half `off[1]`.
  - LW uses the whole word.
- Misaligned load (LH/LHU with `off[0]`=1, or LW with `off`!=0) or reserved `funct3`: `err_o` pulses in WB, `regwren_o` stays 0, `retire_o` still pulses.
- WB: `regwren_o` = captured `regwren && rd != 0 && !err`; `retire_o` = 1.
- WB with a new accept: go to WAIT_MEM or WB per the new `wbsel`. Otherwise go to IDLE.
- Outputs `rd_o`/`datawb_o` hold their last value outside WB; `regwren_o`/`retire_o`/`err_o` are 0 outside WB.

## Timing
- Reset (`rst` low, async): state IDLE, `rd_o`=0, `datawb_o`=0, `regwren_o`=0, `retire_o`=0, `err_o`=0. `ready_o` reads 1 once `rst` is released.
- Non-load accepted in cycle N: outputs valid in N+1. The register file commits at the edge ending N+1.
- Load accepted in N, `mem_rvalid_i` in cycle M ≥ N+1: outputs valid in M+1.
- Back-to-back non-loads: one retire per cycle.
- Load following any instruction: no bubble on accept; the stall lasts until `rvalid`.
- Reset in WAIT_MEM: the pending load is dropped. A late `rvalid` after release is ignored (IDLE).
- `rd_i` = 0 with `regwren_i` = 1: retires with `regwren_o` = 0.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `byp_valid_o` (1), `byp_rd_o` (5) and `byp_data_o` (DWIDTH) for decode operand forwarding.
  - These are combinational copies of `regwren_o`, `rd_o` and `datawb_o`, valid in WB.
  - They let decode read a value written this cycle, because the register file read returns the old value during a write.
- Undefined: these ports do not exist and there is no bypass logic. Decode must stall until the write lands.

## Structure
- `wb_pkg`:
  - `wbsel_e` enum (ALU, MEM, PC4, IMM).
  - `wb_state_e` enum.
  - `funct3` load localparams (LB, LH, LW, LBU, LHU).
- Sub-module `load_align`:
  - Combinational; inputs `funct3`, `off`, `rdata`.
  - Outputs aligned data and a misaligned/illegal flag.

## Test plan
- ALU op: `rd`=5, `wbsel`=0, `alu_res`=0x1234 accepted in N -> N+1: `regwren_o`=1, `rd_o`=5, `datawb_o`=0x1234, `retire_o`=1.
- LB, `off`=3, `rdata`=0x80FF_0011, `rvalid` 3 cycles after accept -> `ready_o`=0 for 3 cycles, then `datawb_o`=0xFFFF_FF80; LBU same -> 0x0000_0080.
- LH with `off`=1 -> `err_o`=1, `regwren_o`=0, `retire_o`=1; LHU `off`=2, `rdata`=0xBEEF_0000 -> 0x0000_BEEF.
- JAL-style `wbsel`=2, `pc`=0x0100_0FFC -> `datawb_o`=0x0100_1000; `rd`=0 with `regwren`=1 -> `regwren_o`=0.
- 4 back-to-back ALU ops -> 4 consecutive `retire_o` pulses; `rst` low mid WAIT_MEM then a stray `rvalid` -> no write, state IDLE.
- `WB_BYPASS_EN`: `byp_valid_o`/`byp_rd_o`/`byp_data_o` equal the register-file write signals every WB cycle.
